// File: rtl/filt_sched.sv
// Round-robin scheduler sharing one FIR engine among CHANNELS sigma-delta streams.
// Requests are raised every DECIM input bits; results return with a channel tag.
module filt_sched #(
    parameter int CHANNELS = 4,
    parameter int DECIM    = 64,
    parameter int TIMEOUT  = 1024
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Enable,
    input  logic [CHANNELS-1:0]           bit_valid,
    output logic                          eng_start,
    output logic [$clog2(CHANNELS)-1:0]   eng_chan,
    input  logic                          eng_push,
    input  logic [15:0]                   eng_dout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   out_data,
    output logic [$clog2(CHANNELS)-1:0]   out_chan,
    output logic                          busy,
    output logic [CHANNELS-1:0]           overrun,
    output logic                          timeout_err,
    input  logic                          err_clr
);
    localparam int CW = $clog2(CHANNELS);
    localparam int DW = $clog2(DECIM);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CH_LAST   = CW'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                state_reg;
    logic [CHANNELS-1:0]   pending_reg;
    logic [CHANNELS-1:0]   pending_next;
    logic [CHANNELS-1:0]   overrun_next;
    logic [CHANNELS-1:0]   wrap;
    logic [CHANNELS-1:0]   grant_mask;
    logic [CW-1:0]         rr_reg;
    logic [CW-1:0]         grant;
    logic                  grant_found;
    logic                  grant_fire;
    logic [WW-1:0]         wait_cnt_reg;

    assign grant_fire = (state_reg == IDLE) && Enable && grant_found && !out_valid;
    assign grant_mask = grant_fire ? (CHANNELS'(1) << grant) : '0;
    assign busy       = (state_reg != IDLE);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [DW-1:0] cnt_reg;

        assign wrap[gi] = Enable && bit_valid[gi] && (cnt_reg == DEC_LAST);
        // A wrap in the grant cycle re-arms the request instead of overrunning.
        assign pending_next[gi] = wrap[gi] ? 1'b1 : (pending_reg[gi] && !grant_mask[gi]);
        assign overrun_next[gi] = (wrap[gi] && pending_reg[gi] && !grant_mask[gi]) ||
                                  (overrun[gi] && !err_clr);

        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset)
                cnt_reg <= '0;
            else if (Enable && bit_valid[gi])
                cnt_reg <= wrap[gi] ? '0 : cnt_reg + 1'b1;
        end
    end

    always_comb begin
        logic [CW-1:0] cand;
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        // Walk backwards so the candidate closest to rr is the last one written.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            cand = CW'((int'(rr_reg) + k) % CHANNELS);
            if (pending_reg[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            overrun      <= '0;
            rr_reg       <= '0;
            wait_cnt_reg <= '0;
            eng_start    <= 1'b0;
            eng_chan     <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_chan     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            eng_start   <= 1'b0;
            pending_reg <= pending_next;
            overrun     <= overrun_next;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (err_clr)
                timeout_err <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (grant_fire) begin
                        eng_chan  <= grant;
                        rr_reg    <= (grant == CH_LAST) ? '0 : grant + 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    eng_start    <= 1'b1;
                    wait_cnt_reg <= '0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    if (eng_push) begin
                        out_data  <= eng_dout;
                        out_chan  <= eng_chan;
                        out_valid <= 1'b1;
                        state_reg <= IDLE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filt_sched.sv
// Directed bench for filt_sched: decimation, round-robin grants, overrun,
// engine timeout, grant-cycle re-arm and asynchronous reset.
module tb_filt_sched;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Enable = 1'b0;
    logic [3:0]  bit_valid = '0;
    logic        eng_start;
    logic [1:0]  eng_chan;
    logic        eng_push = 1'b0;
    logic [15:0] eng_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic        busy;
    logic [3:0]  overrun;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    filt_sched #(.CHANNELS(4), .DECIM(8), .TIMEOUT(16)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .bit_valid(bit_valid),
        .eng_start(eng_start), .eng_chan(eng_chan), .eng_push(eng_push),
        .eng_dout(eng_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] mask, input int n);
        repeat (n) begin
            bit_valid = mask;
            tick();
        end
        bit_valid = '0;
    endtask

    task automatic wait_start(input int ch, input string tag);
        int n = 0;
        while (eng_start !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        check({tag, "_start"}, 32'(eng_start), 32'(1));
        check({tag, "_eng_chan"}, 32'(eng_chan), 32'(ch));
    endtask

    task automatic serve(input int ch, input int dly, input logic [15:0] d, input string tag);
        wait_start(ch, tag);
        repeat (dly) tick();
        eng_push = 1'b1;
        eng_dout = d;
        tick();
        eng_push = 1'b0;
        $display("txn %s ch=%0d data=%04h out_chan=%0d out_data=%04h", tag, ch, d, out_chan, out_data);
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_chan"}, 32'(out_chan), 32'(ch));
    endtask

    task automatic no_start(input int n, input string tag);
        logic seen = 1'b0;
        repeat (n) begin
            tick();
            if (eng_start || out_valid) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'(0));
    endtask

    initial begin
        tick();
        tick();
        check("rst_start", 32'(eng_start), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        check("rst_chan", 32'({eng_chan, out_chan}), 32'(0));
        check("rst_errs", 32'({overrun, timeout_err}), 32'(0));
        Reset  = 1'b0;
        Enable = 1'b1;

        // single channel: exact latency from wrap to start to result
        strobe(4'b0100, 8);
        check("t1_idle", 32'({busy, eng_start}), 32'(0));
        tick();
        check("t1_grant_busy", 32'(busy), 32'(1));
        check("t1_grant_chan", 32'(eng_chan), 32'(2));
        check("t1_grant_nostart", 32'(eng_start), 32'(0));
        tick();
        check("t1_start", 32'(eng_start), 32'(1));
        tick();
        check("t1_pulse_end", 32'(eng_start), 32'(0));
        tick();
        eng_push = 1'b1;
        eng_dout = 16'h1234;
        tick();
        eng_push = 1'b0;
        $display("txn t1 ch=2 data=1234 out_chan=%0d out_data=%04h", out_chan, out_data);
        check("t1_valid", 32'(out_valid), 32'(1));
        check("t1_data", 32'(out_data), 32'h1234);
        check("t1_chan", 32'(out_chan), 32'(2));
        check("t1_busy_done", 32'(busy), 32'(0));
        out_ready = 1'b1;
        tick();
        check("t1_drain", 32'(out_valid), 32'(0));

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mid_rst_data", 32'(out_data), 32'(0));

        // all channels wrap together: round-robin from rr=0
        strobe(4'b1111, 8);
        for (int i = 0; i < 4; i++) serve(i, 3, 16'(16'hA000 + i), "t2");
        tick();
        check("t2_drain", 32'(out_valid), 32'(0));

        // held output blocks ch1 while it wraps again
        out_ready = 1'b0;
        strobe(4'b0011, 8);
        serve(0, 1, 16'h0B00, "t3a");
        strobe(4'b0010, 8);
        check("t3_overrun", 32'(overrun), 32'(4'b0010));
        check("t3_blocked", 32'(busy), 32'(0));
        check("t3_held_chan", 32'(out_chan), 32'(0));
        out_ready = 1'b1;
        tick();
        check("t3_consumed", 32'(out_valid), 32'(0));
        serve(1, 1, 16'h0B11, "t3b");
        no_start(20, "t3_single_result");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_clr", 32'(overrun), 32'(0));

        // engine never answers ch2; ch3 follows
        out_ready = 1'b0;
        strobe(4'b1100, 8);
        wait_start(2, "t4a");
        repeat (15) tick();
        check("t4_not_yet", 32'({busy, timeout_err}), 32'(2'b10));
        tick();
        check("t4_timeout", 32'(timeout_err), 32'(1));
        check("t4_idle", 32'(busy), 32'(0));
        check("t4_no_out", 32'(out_valid), 32'(0));
        serve(3, 1, 16'h0C33, "t4b");
        check("t4_sticky", 32'(timeout_err), 32'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_clr", 32'(timeout_err), 32'(0));

        // ch3 wraps on the very edge it is granted
        strobe(4'b1000, 8);
        check("t5_blocked", 32'(busy), 32'(0));
        strobe(4'b1000, 7);
        out_ready = 1'b1;
        tick();
        check("t5_drained", 32'({out_valid, busy}), 32'(0));
        bit_valid = 4'b1000;
        tick();
        bit_valid = '0;
        check("t5_grant", 32'({busy, eng_chan}), 32'(3'b111));
        check("t5_no_overrun", 32'(overrun), 32'(0));
        serve(3, 1, 16'h5555, "t5a");
        serve(3, 1, 16'h6666, "t5b");
        tick();
        check("t5_overrun_end", 32'(overrun), 32'(0));

        // asynchronous reset during WAIT with ch1 pending
        strobe(4'b0001, 8);
        wait_start(0, "t6");
        strobe(4'b0010, 8);
        check("t6_in_wait", 32'(busy), 32'(1));
        Reset = 1'b1;
        #1;
        check("t6_async_busy", 32'(busy), 32'(0));
        check("t6_async_data", 32'(out_data), 32'(0));
        check("t6_async_chan", 32'({eng_chan, out_chan}), 32'(0));
        tick();
        Reset    = 1'b0;
        eng_push = 1'b1;
        eng_dout = 16'hDEAD;
        tick();
        eng_push = 1'b0;
        check("t6_push_ignored", 32'(out_valid), 32'(0));
        check("t6_data_zero", 32'(out_data), 32'(0));
        no_start(20, "t6_pending_cleared");

        // counters hold while disabled
        Enable = 1'b0;
        strobe(4'b0100, 8);
        Enable = 1'b1;
        no_start(10, "t7_disabled_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
